// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

   function automatic int clog2_pow2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit params_ok(input int width, input int stages);
      return (width >= 4) && ((width & (width - 1)) == 0) &&
             (stages >= 1) && (stages <= clog2_pow2(width) + 1);
   endfunction

   // Index of the register bank placed after prefix level k (0 = none).
   // The last bank is excluded: it always sits after level l and holds the result.
   function automatic int bank_at(input int k, input int l, input int s);
      for (int i = 1; i < s; i++) begin
         if ((i * l) / s == k) return i;
      end
      return 0;
   endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result stream bundle for pipelined_prefix_adder.
interface pipelined_prefix_adder_if #(parameter int WIDTH = 16);
   import prefix_adder_pkg::*;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             ci;
   op_e              op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ovf;

   modport slave (
      input  flush, in_valid, x, y, ci, op, out_ready,
      output in_ready, out_valid, sum, co, ovf
   );

   modport master (
      output flush, in_valid, x, y, ci, op, out_ready,
      input  in_ready, out_valid, sum, co, ovf
   );

endinterface

// File: rtl/prefix_cell.sv
// Kogge-Stone group combine: (G,P) o (G',P') = (G | P&G', P&P').
module prefix_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);

   assign g = g_hi | (p_hi & g_lo);
   assign p = p_hi & p_lo;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone add/sub with valid/ready stream, flush and global stall.
// Entry 0 of every G/P vector is the carry-in (bit -1); entry i+1 is operand bit i.
module pipelined_prefix_adder
   import prefix_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pipelined_prefix_adder_if.slave  bus
);

   localparam int L = clog2_pow2(WIDTH);
   localparam int N = WIDTH + 1;

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $fatal(1, "pipelined_prefix_adder: illegal WIDTH/STAGES");
   end

   logic [L:0][N-1:0]     g_c, p_c;
   logic [L:0][WIDTH-1:0] h_c;
   logic [L-1:0][N-1:0]     g_s, p_s;
   logic [L-1:0][WIDTH-1:0] h_s;

   logic              stall, en;
   logic [WIDTH-1:0]  yb;
   logic              cin;
   logic [STAGES:1]   vld_d, vld_q;
   logic [STAGES:0]   vld_pipe;
   logic [WIDTH-1:0]  sum_d, sum_q;
   logic              co_d, co_q, ovf_d, ovf_q;

   // Global enable: every bank holds together while the consumer stalls.
   assign stall = vld_q[STAGES] & ~bus.out_ready;
   assign en    = ~stall;

   assign yb     = (bus.op == OP_SUB) ? ~bus.y : bus.y;
   assign cin    = (bus.op == OP_SUB) ? 1'b1 : bus.ci;
   assign g_c[0] = {bus.x & yb, cin};
   assign p_c[0] = {bus.x | yb, 1'b0};
   assign h_c[0] = bus.x ^ yb;

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int D = 1 << (k - 1);
      assign h_c[k] = h_s[k-1];
      for (genvar i = 0; i < N; i++) begin : g_bit
         if (i >= D) begin : g_cell
            prefix_cell u_cell (
               .g_hi (g_s[k-1][i]),
               .p_hi (p_s[k-1][i]),
               .g_lo (g_s[k-1][i-D]),
               .p_lo (p_s[k-1][i-D]),
               .g    (g_c[k][i]),
               .p    (p_c[k][i])
            );
         end else begin : g_pass
            assign g_c[k][i] = g_s[k-1][i];
            assign p_c[k][i] = p_s[k-1][i];
         end
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_bank
      if (bank_at(k, L, STAGES) != 0) begin : g_reg
         logic [N-1:0]     g_q, p_q;
         logic [WIDTH-1:0] h_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               g_q <= '0;
               p_q <= '0;
               h_q <= '0;
            end else if (en) begin
               g_q <= g_c[k];
               p_q <= p_c[k];
               h_q <= h_c[k];
            end
         end
         assign g_s[k] = g_q;
         assign p_s[k] = p_q;
         assign h_s[k] = h_q;
      end else begin : g_wire
         assign g_s[k] = g_c[k];
         assign p_s[k] = p_c[k];
         assign h_s[k] = h_c[k];
      end
   end

   // After L levels entry i covers bits i-1..-1, except entry WIDTH which
   // still needs one more combine with the carry-in to form the carry-out.
   always_comb begin
      sum_d = h_c[L] ^ g_c[L][WIDTH-1:0];
      co_d  = g_c[L][WIDTH] | (p_c[L][WIDTH] & g_c[L][0]);
      ovf_d = co_d ^ g_c[L][WIDTH-1];
   end

   assign vld_pipe = {vld_q, bus.in_valid};

   // Flush beats stall; it also drops the beat offered in the same cycle.
   always_comb begin
      vld_d = vld_q;
      if (bus.flush) begin
         vld_d = '0;
      end else if (en) begin
         for (int s = 1; s <= STAGES; s++) vld_d[s] = vld_pipe[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         sum_q <= '0;
         co_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         if (en) begin
            sum_q <= sum_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
         end
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = vld_q[STAGES];
   assign bus.sum       = sum_q;
   assign bus.co        = co_q;
   assign bus.ovf       = ovf_q;

endmodule
